// File: rtl/counter_updown_tc.sv
// counter_updown_tc
//   Up/down iteration counter with parallel load, a run-time upper limit,
//   and a compile-time choice of saturate or wrap at the terminal value.
//   Emits a registered one-cycle terminal-count pulse on arrival.
//
// Parameters
//   dw    : width of result, load_val and limit
//   WIDTH : value of result after reset (not clamped to limit)
//   WRAP  : 0 = saturate at the terminal value, 1 = wrap around
//
// Ports
//   clk      in   clock, all state changes on posedge
//   reset    in   synchronous, active-high, highest priority
//   ena      in   count enable, one step per cycle
//   up       in   step direction: 1 = increment, 0 = decrement
//   load     in   synchronous load strobe (beats ena)
//   load_val in   value to load, clamped to limit
//   limit    in   upper terminal value, sampled every cycle
//   result   out  registered count
//   zero     out  combinational result == 0
//   at_limit out  combinational result >= limit
//   tc       out  registered terminal-count pulse
module counter_updown_tc #(
  parameter int dw    = 8,
  parameter int WIDTH = 7,
  parameter bit WRAP  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          up,
  input  logic          load,
  input  logic [dw-1:0] load_val,
  input  logic [dw-1:0] limit,
  output logic [dw-1:0] result,
  output logic          zero,
  output logic          at_limit,
  output logic          tc
);

  logic [dw-1:0] result_reg, result_next;
  logic [dw-1:0] term;
  logic          tc_reg, tc_next;

  always_comb begin
    result_next = result_reg;
    tc_next     = 1'b0;
    // Terminal value depends on the direction sampled this cycle.
    term        = up ? limit : '0;

    if (load) begin
      result_next = (load_val > limit) ? limit : load_val;
    end else if (ena) begin
      if (up) begin
        // Compare before adding so the increment can never overflow; a
        // result above a freshly lowered limit snaps to it (or wraps).
        if (result_reg < limit) result_next = result_reg + dw'(1);
        else if (WRAP)          result_next = '0;
        else                    result_next = limit;
      end else begin
        if (result_reg != '0)   result_next = result_reg - dw'(1);
        else if (WRAP)          result_next = limit;
        else                    result_next = '0;
      end
      // Pulse only on arrival: staying on the terminal or leaving it by
      // wrapping does not count.
      tc_next = (result_next == term) && (result_reg != term);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg <= dw'(WIDTH);
      tc_reg     <= 1'b0;
    end else begin
      result_reg <= result_next;
      tc_reg     <= tc_next;
    end
  end

  assign result   = result_reg;
  assign tc       = tc_reg;
  assign zero     = (result_reg == '0);
  assign at_limit = (result_reg >= limit);

endmodule

// File: doc/counter_updown_tc.md
# counter_updown_tc

Parametrised successor to the lab-1 down counter, used as the iteration counter for the multiplier datapath. Counts up or down on enable, with:
- a synchronous parallel load;
- a run-time programmable upper limit;
- a compile-time choice of saturate or wrap at the terminal value;
- a registered one-cycle terminal-count pulse that the multiplier controller uses to end a shift-add sequence.

## Interface
Parameters:
- dw, 8, width of count, load value and limit.
- WIDTH, 7, reset value of result; must satisfy WIDTH < 2**dw.
- WRAP, 0, terminal behaviour: 0 = saturate, 1 = wrap.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; highest priority.
- ena  input  1  count enable; one step per cycle while high.
- up  input  1  direction for the step: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  dw  value loaded when load=1.
- limit  input  dw  upper terminal value, sampled every cycle.
- result  output  dw  registered count.
- zero  output  1  combinational, result == 0.
- at_limit  output  1  combinational, result >= limit.
- tc  output  1  registered terminal-count pulse.

## Operation
- Priority at each posedge: reset > load > ena. With ena=0 and load=0, result and all state hold.
- Reset:
  - result <= WIDTH, tc <= 0.
  - WIDTH is not clamped to limit.
- Load:
  - result <= min(load_val, limit); tc <= 0.
  - ena and up are ignored that cycle.
- Terminal value: 0 when up=0, limit when up=1.
- Down step (ena=1, up=0):
  - result > 0: result <= result-1.
  - result == 0, WRAP=0: hold at 0.
  - result == 0, WRAP=1: result <= limit.
- Up step (ena=1, up=1):
  - result < limit: result <= result+1.
  - result >= limit, WRAP=0: result <= limit. If limit was lowered below result, result snaps down to limit.
  - result >= limit, WRAP=1: result <= 0.
- tc:
  - tc <= 1 only on a counting step whose next result equals the terminal value for the current direction and whose current result does not.
  - Otherwise tc <= 0. This includes: holding at saturation, a wrap step leaving the terminal, load, reset, and ena=0.
- Arithmetic is unsigned, dw bits. No step ever produces a value outside [0, 2**dw-1]; no natural modulo overflow is relied on.
- up may change on any cycle. Each step uses the up value sampled at that edge.
- limit may change on any cycle. Terminal comparisons always use the current limit.
- limit = 0:
  - Up steps from 0 are terminal steps: hold (WRAP=0) or 0 -> 0 (WRAP=1).
  - tc never fires from 0 in either direction.

## Timing
- Latency of one cycle from ena/load/reset sampled high to result updated.
- tc is asserted in the same cycle result first shows the terminal value. It is high for exactly one cycle per arrival.
- zero and at_limit track result (and limit) with no added latency. They are valid in the cycle after reset.
- Reset mid-count aborts the count. The next cycle shows result=WIDTH and tc=0, whatever ena/load were doing.
- Back-to-back load on consecutive cycles: each load overwrites. tc stays 0 throughout.

## Test plan
- Reset with dw=8, WIDTH=7, WRAP=0, limit=255:
  - reset 1 cycle -> result=7, tc=0, zero=0.
  - Then ena=1, up=0 for 9 cycles -> 6,5,...,0,0,0; tc high only in the cycle result=0.
- WRAP=1, limit=5, result=1, ena=1, up=0 -> results 0,5,4; tc high only while result=0.
- WRAP=0, limit=10, load_val=200, load=1 (ena=1 same cycle) -> result=10, tc=0, at_limit=1. Then up=1 for 3 cycles -> result stays 10, tc stays 0.
- WRAP=0, result=8, up=1, limit=9, ena=1 -> result=9, tc=1. Drop limit to 4 next cycle with up=1 -> result=4, tc=1. Next cycle -> result=4, tc=0.
- Reset priority: count down from 7 with ena=1, load=1, load_val=3 and reset=1 together at result=4 -> next result=7, tc=0.
- limit=0, WRAP=1, result=0, ena=1, alternating up=1/0 for 4 cycles -> result stays 0, tc never asserted.
